alu_ir_mar_datapath: RTL and testbench
======================================

Name: alu_ir_mar_datapath

Overview:
- Core datapath slice of the multicycle ARM-style CPU: combinational 32-bit ALU plus three clocked registers.
- Registers: Instruction Register (IR), Memory Address Register (MAR), condition-flag register (FR).
- ALU operands come from the register-file port A and the operand-B mux; the opcode comes from the control unit or IR[24:21].
- The ALU result feeds the MAR, the register file and MDR mux E; the IR captures the memory data-out bus.

Parameters:
- WIDTH, 32, datapath width of ALU operands, result, IR and MAR.

Ports:
- CLK  in  1  single system clock; all state updates on rising edge
- CLR  in  1  synchronous active-high reset
- pa  in  32  ALU operand A (register-file port A)
- pb  in  32  ALU operand B (operand-B mux output)
- op  in  5  ALU opcode
- carry_in  in  1  carry input for ADC/SBC/RSC and the logical-op C flag
- ir_d  in  32  memory data-out bus
- ir_ld  in  1  IR load enable
- mar_ld  in  1  MAR load enable
- fr_ld  in  1  flag register load enable
- result  out  32  ALU result (combinational)
- flag_z, flag_n, flag_c, flag_v  out  1 each  combinational ALU flags
- ir_q  out  32  IR contents
- mar_q  out  32  MAR contents
- fr_q  out  4  registered flags {N,Z,C,V}

Behaviour:
- Reset: on a rising CLK edge with CLR=1, ir_q, mar_q and fr_q all go to 0.
  - CLR has priority over every load enable.
  - Combinational outputs are unaffected by CLR.
- IR: at a rising edge with CLR=0 and ir_ld=1, ir_q <= ir_d; otherwise it holds.
- MAR: at a rising edge with CLR=0 and mar_ld=1, mar_q <= result (the current ALU output); otherwise it holds.
- FR: at a rising edge with CLR=0 and fr_ld=1, fr_q <= {flag_n, flag_z, flag_c, flag_v}; otherwise it holds.
- Simultaneous enables are independent; all enabled registers update on the same edge.
- Load latency is 1 cycle; values are visible after the edge.
- ALU opcodes (result is modulo 2^32; B' = ~B):
  - 0 AND A&B; 1 EOR A^B; 2 SUB A-B; 3 RSB B-A
  - 4 ADD A+B; 5 ADC A+B+cin; 6 SBC A+B'+cin; 7 RSC B+A'+cin
  - 8 TST A&B; 9 TEQ A^B; 10 CMP A-B; 11 CMN A+B
  - 12 ORR A|B; 13 MOV B; 14 BIC A&B'; 15 MVN B'
  - 16 A+4 (PC increment); 17 pass A; 18 A+B+4
  - 19–31: result 0, C=carry_in, V=0
- Test ops 8–11 still drive result with the computed value; suppressing write-back is the control unit's job.
- Flags:
  - Z=(result==0); N=result[31].
  - Arithmetic ops: C = carry out of bit 31 with subtraction done as A+B'+1, so C=1 means no borrow; V = signed overflow (operand signs equal and result sign differs, evaluated on the effective addends).
  - Logical ops (0,1,8,9,12–15): C=carry_in, V=0.
- The ALU is purely combinational with no clock dependence; result is valid within the same cycle for mar_ld capture.

Test Plan:
- CLR=1 with ir_ld=mar_ld=fr_ld=1, one edge -> ir_q=0, mar_q=0, fr_q=0.
- ir_d=0xE2811004, ir_ld=1, one edge; then ir_ld=0, ir_d=0xFFFFFFFF, another edge -> ir_q=0xE2811004 held.
- op=16, pa=0x0000000C, mar_ld=1, one edge -> result=0x10 combinationally; mar_q=0x00000010 after the edge.
- op=4, pa=0x7FFFFFFF, pb=1 -> result=0x80000000, N=1, Z=0, C=0, V=1. Then fr_ld=1, one edge -> fr_q=4'b1001.
- op=10, pa=5, pb=5 -> result=0, Z=1, C=1, V=0, N=0.
- op=2, pa=3, pb=5 -> result=0xFFFFFFFE, N=1, C=0.
- op=5, pa=0xFFFFFFFF, pb=0, carry_in=1 -> result=0, Z=1, C=1.
- op=15, pb=0, carry_in=1 -> result=0xFFFFFFFF, C=1, V=0.

Source files
------------

// File: rtl/alu_ir_mar_datapath_if.sv
// Bus bundle between the control/operand side and the ALU/IR/MAR/FR datapath slice.
interface alu_ir_mar_datapath_if #(
  parameter int unsigned WIDTH = 32
);
  logic [WIDTH-1:0] pa;
  logic [WIDTH-1:0] pb;
  logic [4:0]       op;
  logic             carry_in;
  logic [WIDTH-1:0] ir_d;
  logic             ir_ld;
  logic             mar_ld;
  logic             fr_ld;
  logic [WIDTH-1:0] result;
  logic             flag_z;
  logic             flag_n;
  logic             flag_c;
  logic             flag_v;
  logic [WIDTH-1:0] ir_q;
  logic [WIDTH-1:0] mar_q;
  logic [3:0]       fr_q;

  modport master (
    output pa, pb, op, carry_in, ir_d, ir_ld, mar_ld, fr_ld,
    input  result, flag_z, flag_n, flag_c, flag_v, ir_q, mar_q, fr_q
  );

  modport slave (
    input  pa, pb, op, carry_in, ir_d, ir_ld, mar_ld, fr_ld,
    output result, flag_z, flag_n, flag_c, flag_v, ir_q, mar_q, fr_q
  );
endinterface

// File: rtl/alu_ir_mar_datapath.sv
// Multicycle CPU datapath slice: combinational ALU with flags, plus IR, MAR and
// flag registers sharing one synchronous active-high clear.
module alu_ir_mar_datapath #(
  parameter int unsigned WIDTH = 32
) (
  input logic                   CLK,
  input logic                   CLR,
  alu_ir_mar_datapath_if.slave  bus
);
  localparam int unsigned MSB = WIDTH - 1;

  logic [WIDTH-1:0] a_e;
  logic [WIDTH-1:0] b_e;
  logic [WIDTH+1:0] k;
  logic [WIDTH+1:0] sum;
  logic             arith;
  logic [WIDTH-1:0] res;
  logic             c;
  logic             v;

  // Every arithmetic op is an add of two effective addends plus a small constant;
  // two guard bits hold the carry of A+B+4.
  always_comb begin
    a_e   = bus.pa;
    b_e   = bus.pb;
    k     = '0;
    arith = 1'b0;
    res   = '0;
    c     = bus.carry_in;
    v     = 1'b0;
    unique case (bus.op)
      5'd0, 5'd8:   res = bus.pa & bus.pb;
      5'd1, 5'd9:   res = bus.pa ^ bus.pb;
      5'd12:        res = bus.pa | bus.pb;
      5'd13:        res = bus.pb;
      5'd14:        res = bus.pa & ~bus.pb;
      5'd15:        res = ~bus.pb;
      5'd17:        res = bus.pa;
      5'd2, 5'd10:  begin arith = 1'b1; b_e = ~bus.pb; k = (WIDTH+2)'(1); end
      5'd3:         begin arith = 1'b1; a_e = bus.pb; b_e = ~bus.pa; k = (WIDTH+2)'(1); end
      5'd4, 5'd11:  arith = 1'b1;
      5'd5:         begin arith = 1'b1; k = (WIDTH+2)'(bus.carry_in); end
      5'd6:         begin arith = 1'b1; b_e = ~bus.pb; k = (WIDTH+2)'(bus.carry_in); end
      5'd7:         begin arith = 1'b1; a_e = bus.pb; b_e = ~bus.pa; k = (WIDTH+2)'(bus.carry_in); end
      5'd16:        begin arith = 1'b1; b_e = WIDTH'(4); end
      5'd18:        begin arith = 1'b1; k = (WIDTH+2)'(4); end
      default:      res = '0;
    endcase
    sum = {2'b00, a_e} + {2'b00, b_e} + k;
    if (arith) begin
      res = sum[WIDTH-1:0];
      c   = |sum[WIDTH+1:WIDTH];
      v   = (a_e[MSB] == b_e[MSB]) && (sum[MSB] != a_e[MSB]);
    end
  end

  assign bus.result = res;
  assign bus.flag_z = (res == '0);
  assign bus.flag_n = res[MSB];
  assign bus.flag_c = c;
  assign bus.flag_v = v;

  // Clear beats every load; enabled registers update independently on one edge.
  always_ff @(posedge CLK) begin
    if (CLR) begin
      bus.ir_q  <= '0;
      bus.mar_q <= '0;
      bus.fr_q  <= '0;
    end else begin
      if (bus.ir_ld)  bus.ir_q  <= bus.ir_d;
      if (bus.mar_ld) bus.mar_q <= res;
      if (bus.fr_ld)  bus.fr_q  <= {res[MSB], (res == '0), c, v};
    end
  end
endmodule

// File: tb/tb_alu_ir_mar_datapath.sv
// Scoreboard bench for alu_ir_mar_datapath: directed cases plus randomized ops and loads.
module tb_alu_ir_mar_datapath;
  logic CLK = 1'b0;
  logic CLR;
  always #5 CLK = ~CLK;

  alu_ir_mar_datapath_if #(.WIDTH(32)) bus ();
  alu_ir_mar_datapath #(.WIDTH(32)) dut (.CLK(CLK), .CLR(CLR), .bus(bus));

  int checks = 0;
  int errors = 0;
  string       tag_q[$];
  logic [31:0] val_q[$];
  logic [31:0] m_ir, m_mar;
  logic [3:0]  m_fr;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  task automatic push(input string tag, input logic [31:0] val);
    tag_q.push_back(tag);
    val_q.push_back(val);
  endtask

  task automatic pop_check(input logic [31:0] got);
    if (val_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_empty got=%08h exp=none", got);
    end else begin
      check(tag_q.pop_front(), got, val_q.pop_front());
    end
  endtask

  function automatic longint sx(input logic [31:0] x);
    return longint'($signed(x));
  endfunction

  // Reference ALU: unsigned 64-bit sum for C, true signed range test for V.
  function automatic logic [35:0] model(input logic [4:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic cin);
    logic [31:0] r, na, nb;
    logic [63:0] t;
    longint s;
    logic c, v, ar;
    na = ~a; nb = ~b;
    r = '0; c = cin; v = 1'b0; ar = 1'b0; t = '0; s = 0;
    case (op)
      5'd0, 5'd8:  r = a & b;
      5'd1, 5'd9:  r = a ^ b;
      5'd12:       r = a | b;
      5'd13:       r = b;
      5'd14:       r = a & nb;
      5'd15:       r = nb;
      5'd17:       r = a;
      5'd2, 5'd10: begin ar = 1; t = {32'b0, a} + {32'b0, nb} + 64'd1; s = sx(a) - sx(b); end
      5'd3:        begin ar = 1; t = {32'b0, b} + {32'b0, na} + 64'd1; s = sx(b) - sx(a); end
      5'd4, 5'd11: begin ar = 1; t = {32'b0, a} + {32'b0, b}; s = sx(a) + sx(b); end
      5'd5:        begin ar = 1; t = {32'b0, a} + {32'b0, b} + 64'(cin); s = sx(a) + sx(b) + longint'(cin); end
      5'd6:        begin ar = 1; t = {32'b0, a} + {32'b0, nb} + 64'(cin); s = sx(a) + sx(nb) + longint'(cin); end
      5'd7:        begin ar = 1; t = {32'b0, b} + {32'b0, na} + 64'(cin); s = sx(b) + sx(na) + longint'(cin); end
      5'd16:       begin ar = 1; t = {32'b0, a} + 64'd4; s = sx(a) + 4; end
      5'd18:       begin ar = 1; t = {32'b0, a} + {32'b0, b} + 64'd4; s = sx(a) + sx(b) + 4; end
      default:     r = '0;
    endcase
    if (ar) begin
      r = t[31:0];
      c = |t[63:32];
      v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
    end
    return {r, r[31], (r == 32'd0), c, v};
  endfunction

  task automatic set_alu(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic cin);
    bus.op = op; bus.pa = a; bus.pb = b; bus.carry_in = cin;
  endtask

  task automatic sample_alu(input logic chk_flags);
    #1;
    pop_check(bus.result);
    if (chk_flags) pop_check(32'({bus.flag_n, bus.flag_z, bus.flag_c, bus.flag_v}));
  endtask

  // Directed ALU case with hand-derived constants.
  task automatic alu_exp(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic cin, input logic [31:0] er, input logic [3:0] ef,
                         input logic chk_flags);
    set_alu(op, a, b, cin);
    push($sformatf("res_op%0d", op), er);
    if (chk_flags) push($sformatf("nzcv_op%0d", op), 32'(ef));
    sample_alu(chk_flags);
  endtask

  // One clock edge: predict registers from the current ALU model, then compare.
  task automatic edge_cycle(input logic clr, input logic ild, input logic mld,
                            input logic fld, input logic [31:0] d);
    logic [35:0] m;
    CLR = clr; bus.ir_ld = ild; bus.mar_ld = mld; bus.fr_ld = fld; bus.ir_d = d;
    m = model(bus.op, bus.pa, bus.pb, bus.carry_in);
    if (clr) begin
      m_ir = '0; m_mar = '0; m_fr = '0;
    end else begin
      if (ild) m_ir = d;
      if (mld) m_mar = m[35:4];
      if (fld) m_fr = m[3:0];
    end
    push("ir_q", m_ir);
    push("mar_q", m_mar);
    push("fr_q", 32'(m_fr));
    @(posedge CLK);
    #1;
    pop_check(bus.ir_q);
    pop_check(bus.mar_q);
    pop_check(32'(bus.fr_q));
    CLR = 1'b0; bus.ir_ld = 1'b0; bus.mar_ld = 1'b0; bus.fr_ld = 1'b0;
  endtask

  initial begin
    logic [35:0] m;
    logic [4:0]  rop;
    CLR = 1'b1;
    bus.ir_ld = 1'b1; bus.mar_ld = 1'b1; bus.fr_ld = 1'b1;
    bus.ir_d = 32'hDEADBEEF;
    set_alu(5'd4, 32'h7FFFFFFF, 32'd1, 1'b0);
    m_ir = 'x; m_mar = 'x; m_fr = 'x;

    // Clear with all loads asserted
    edge_cycle(1'b1, 1'b1, 1'b1, 1'b1, 32'hDEADBEEF);

    // IR load then hold
    edge_cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'hE2811004);
    edge_cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'hFFFFFFFF);
    check("ir_hold_const", bus.ir_q, 32'hE2811004);

    // PC increment into MAR
    alu_exp(5'd16, 32'h0000000C, 32'd0, 1'b0, 32'h00000010, 4'b0000, 1'b1);
    edge_cycle(1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
    check("mar_const", bus.mar_q, 32'h00000010);

    // Signed overflow, captured into FR
    alu_exp(5'd4, 32'h7FFFFFFF, 32'd1, 1'b0, 32'h80000000, 4'b1001, 1'b1);
    edge_cycle(1'b0, 1'b0, 1'b0, 1'b1, 32'd0);
    check("fr_const", 32'(bus.fr_q), 32'h9);

    alu_exp(5'd10, 32'd5, 32'd5, 1'b0, 32'd0, 4'b0110, 1'b1);
    alu_exp(5'd2, 32'd3, 32'd5, 1'b0, 32'hFFFFFFFE, 4'b1000, 1'b1);
    alu_exp(5'd5, 32'hFFFFFFFF, 32'd0, 1'b1, 32'd0, 4'b0110, 1'b1);
    alu_exp(5'd15, 32'd0, 32'd0, 1'b1, 32'hFFFFFFFF, 4'b1010, 1'b1);
    alu_exp(5'd3, 32'd1, 32'd3, 1'b0, 32'd2, 4'b0010, 1'b1);
    alu_exp(5'd19, 32'h12345678, 32'h9ABCDEF0, 1'b1, 32'd0, 4'b0110, 1'b1);
    alu_exp(5'd31, 32'h12345678, 32'h9ABCDEF0, 1'b0, 32'd0, 4'b0100, 1'b1);
    alu_exp(5'd18, 32'd1, 32'd2, 1'b0, 32'd7, 4'b0000, 1'b0);
    alu_exp(5'd14, 32'hFF00FF00, 32'h0F0F0F0F, 1'b1, 32'hF000F000, 4'b1010, 1'b1);

    // Clear priority after registers hold nonzero values
    set_alu(5'd13, 32'd0, 32'hA5A5A5A5, 1'b0);
    edge_cycle(1'b0, 1'b1, 1'b1, 1'b1, 32'h13572468);
    edge_cycle(1'b1, 1'b1, 1'b1, 1'b1, 32'hFFFFFFFF);

    // Randomized ops with random load enables and occasional clear
    for (int i = 0; i < 60; i++) begin
      rop = 5'($urandom_range(0, 31));
      set_alu(rop, $urandom, ($urandom_range(0, 3) == 0) ? ~bus.pa : $urandom,
              1'($urandom_range(0, 1)));
      m = model(bus.op, bus.pa, bus.pb, bus.carry_in);
      push($sformatf("rnd_res_op%0d", rop), m[35:4]);
      if (rop != 5'd18) push($sformatf("rnd_nzcv_op%0d", rop), 32'(m[3:0]));
      sample_alu(rop != 5'd18);
      edge_cycle($urandom_range(0, 7) == 0, 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
    end

    check("scoreboard_drained", 32'(val_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
